// File: rtl/enigma_pkg.sv
// Shared Enigma datapath definitions: alphabet size, rotor wirings and mod-26 helpers.
package enigma_pkg;
  localparam int N = 26;

  typedef logic [4:0]          idx_t;
  typedef logic [N-1:0][4:0]   wiring_t;

  // Wiring strings are written left to right as contact A..Z.
  function automatic wiring_t str2wiring(input logic [8*N-1:0] s);
    wiring_t w;
    for (int k = 0; k < N; k++) w[k] = 5'(s[8*(N-1-k) +: 8] - 8'd65);
    return w;
  endfunction

  localparam wiring_t ROTOR_I   = str2wiring("EKMFLGDQVZNTOWYHXUSPAIBRCJ");
  localparam wiring_t ROTOR_II  = str2wiring("AJDKSIRUXBLHWTMCQGZNPYFVOE");
  localparam wiring_t ROTOR_III = str2wiring("BDFHJLCPRTXVZNYEIWGAKMUSQO");
  localparam wiring_t ROTOR_IV  = str2wiring("ESOVPZJAYQUIRHXLNFTGKDCMWB");
  localparam wiring_t ROTOR_V   = str2wiring("VZBRGITYUPSDNHLXAWMJQOFECK");

  function automatic wiring_t rotor_wiring(input int sel);
    case (sel)
      1:       return ROTOR_I;
      3:       return ROTOR_III;
      4:       return ROTOR_IV;
      5:       return ROTOR_V;
      default: return ROTOR_II;
    endcase
  endfunction

  function automatic idx_t mod26_add(input idx_t a, input idx_t b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 6'd26) ? 5'(s - 6'd26) : s[4:0];
  endfunction

  function automatic idx_t mod26_sub(input idx_t a, input idx_t b);
    logic [5:0] s;
    s = {1'b0, a} + 6'd26 - {1'b0, b};
    return (s >= 6'd26) ? 5'(s - 6'd26) : s[4:0];
  endfunction
endpackage

// File: rtl/rotor_inverse_if.sv
// Valid/ready request and response channels of one return-path rotor stage.
interface rotor_inverse_if;
  import enigma_pkg::*;
  logic in_valid;
  logic in_ready;
  idx_t data_in;
  idx_t position;
  logic out_valid;
  logic out_ready;
  idx_t data_out;
  logic err_out;

  modport slave  (input  in_valid, data_in, position, out_ready,
                  output in_ready, out_valid, data_out, err_out);
  modport master (output in_valid, data_in, position, out_ready,
                  input  in_ready, out_valid, data_out, err_out);
endinterface

// File: rtl/rotor_inv_table.sv
// Inverse wiring table, filled one entry per cycle from the forward wiring after reset.
module rotor_inv_table
  import enigma_pkg::*;
#(
  parameter int ROTOR_SEL = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  idx_t i_addr,
  output idx_t o_data,
  output logic o_done
);
  localparam wiring_t FWD = rotor_wiring(ROTOR_SEL);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          r_state;
  idx_t            r_k;
  idx_t [N-1:0]    r_tab;
  logic            r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_k     <= '0;
      r_tab   <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_tab[FWD[r_k]] <= r_k;
          if (r_k == 5'(N-1)) begin
            r_state <= S_RUN;
            r_done  <= 1'b1;
          end else begin
            r_k <= r_k + 5'd1;
          end
        end
        default: r_done <= 1'b1;
      endcase
    end
  end

  // Out-of-range addresses only occur for illegal requests whose result is discarded.
  assign o_data = (i_addr < 5'(N)) ? r_tab[i_addr] : '0;
  assign o_done = r_done;
endmodule

// File: rtl/rotor_inverse.sv
// Return-path rotor stage: (inv[(d+pos) mod 26] - pos) mod 26, one letter per handshake.
module rotor_inverse #(
  parameter int ROTOR_SEL = 2,
  parameter int N         = 26
) (
  input  logic               clk,
  input  logic               rst_n,
  rotor_inverse_if.slave     bus,
  output logic               o_init_done
);
  import enigma_pkg::*;

  idx_t w_c;
  idx_t w_w;
  idx_t w_res;
  logic w_ill;
  logic w_done;
  logic w_acc;

  logic r_out_valid;
  idx_t r_data;
  logic r_err;

  rotor_inv_table #(.ROTOR_SEL(ROTOR_SEL)) u_tab (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_addr (w_c),
    .o_data (w_w),
    .o_done (w_done)
  );

  assign w_ill = (bus.data_in >= 5'(N)) || (bus.position >= 5'(N));
  assign w_c   = mod26_add(bus.data_in, bus.position);
  assign w_res = mod26_sub(w_w, bus.position);

  assign bus.in_ready = w_done && (!r_out_valid || bus.out_ready);
  assign w_acc        = bus.in_valid && bus.in_ready;

  // A new accept overrides the drain so back-to-back letters keep out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_err       <= 1'b0;
    end else if (w_acc) begin
      r_out_valid <= 1'b1;
      r_data      <= w_ill ? 5'h1F : w_res;
      r_err       <= w_ill;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.data_out  = r_data;
  assign bus.err_out   = r_err;
  assign o_init_done   = w_done;
endmodule

// File: tb/tb_rotor_inverse.sv
// Directed bench for rotor_inverse (rotor II) with an independent inverse-wiring model.
module tb_rotor_inverse;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done;
  int   n_chk = 0;
  int   n_err = 0;
  int   inv_m[26];

  rotor_inverse_if bus();

  rotor_inverse #(.ROTOR_SEL(2), .N(26)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_init_done (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input int d, input int p);
    if (d > 25 || p > 25) return 31;
    return (inv_m[(d + p) % 26] - p + 26) % 26;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    int bad = 0;
    while (!init_done && n < 60) begin
      if (bus.in_ready || bus.out_valid) bad++;
      step();
      n++;
    end
    chk({tag, "_cycles"}, n, 26);
    chk({tag, "_idle"}, bad, 0);
  endtask

  task automatic single(input string tag, input logic [4:0] d, input logic [4:0] p,
                        input int exp_d, input int exp_e);
    int n = 0;
    bus.data_in  = d;
    bus.position = p;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_accept"}, int'(n < 20), 1);
    step();
    bus.in_valid = 1'b0;
    chk({tag, "_valid"}, int'(bus.out_valid), 1);
    chk({tag, "_data"}, int'(bus.data_out), exp_d);
    chk({tag, "_err"}, int'(bus.err_out), exp_e);
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    string wire_s = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    for (int k = 0; k < 26; k++) inv_m[int'(wire_s[k]) - 65] = k;

    // Request raised during reset and held across INIT must not be consumed early.
    bus.in_valid  = 1'b1;
    bus.data_in   = 5'd9;
    bus.position  = 5'd0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_done", int'(init_done), 0);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_data", int'(bus.data_out), 0);
    chk("rst_err", int'(bus.err_out), 0);
    rst_n = 1'b1;
    wait_init("boot");

    single("J_pos0", 5'd9, 5'd0, 1, 0);
    single("wrap_p25", 5'd1, 5'd25, 1, 0);
    single("wrap_d25", 5'd25, 5'd3, 12, 0);
    single("wrap_p1", 5'd8, 5'd1, 0, 0);
    single("ill_d26", 5'd26, 5'd0, 31, 1);
    single("ill_p30", 5'd0, 5'd30, 31, 1);
    step();
    chk("drain_valid", int'(bus.out_valid), 0);

    // Back-pressure: result holds, stage stalls, then both sides move in one edge.
    bus.out_ready = 1'b0;
    single("bp_first", 5'd3, 5'd3, 14, 0);
    bus.data_in  = 5'd4;
    bus.position = 5'd0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_hold_data", int'(bus.data_out), 14);
      chk("bp_in_ready", int'(bus.in_ready), 0);
      chk("bp_hold_valid", int'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp_next_data", int'(bus.data_out), 25);
    chk("bp_next_valid", int'(bus.out_valid), 1);
    bus.in_valid = 1'b0;
    step();
    chk("bp_drained", int'(bus.out_valid), 0);

    // Full-throughput sweep of every (data_in, position) pair.
    bus.in_valid = 1'b1;
    for (int p = 0; p < 26; p++) begin
      for (int d = 0; d < 26; d++) begin
        bus.data_in  = 5'(d);
        bus.position = 5'(p);
        step();
        chk($sformatf("sweep_d%0d_p%0d", d, p),
            int'({bus.out_valid, bus.err_out, bus.data_out}), (1 << 6) | model(d, p));
      end
    end
    bus.in_valid = 1'b0;
    step();

    // Reset with a stalled result, then reset again partway through the build.
    bus.out_ready = 1'b0;
    single("pre_rst", 5'd9, 5'd0, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(bus.out_valid), 0);
    chk("arst_data", int'(bus.data_out), 0);
    chk("arst_err", int'(bus.err_out), 0);
    chk("arst_in_ready", int'(bus.in_ready), 0);
    chk("arst_done", int'(init_done), 0);
    step();
    rst_n = 1'b1;
    repeat (12) step();
    chk("mid_init_done", int'(init_done), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", int'(bus.in_ready), 0);
    step();
    rst_n = 1'b1;
    wait_init("rebuild");
    bus.out_ready = 1'b1;
    single("post_d25", 5'd25, 5'd3, 12, 0);
    single("post_J", 5'd9, 5'd0, 1, 0);
    single("post_p25", 5'd3, 5'd25, model(3, 25), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
